// File: rtl/if_id_queue.sv
// Fetch-to-decode instruction buffer: a small FIFO of {pc, instr} pairs with
// valid/ready on both sides and a synchronous flush for wrong-path discard.
module if_id_queue #(
  parameter int          DEPTH = 2,
  parameter int          XLEN  = 32,
  parameter logic [31:0] NOP   = 32'h00000013
) (
  input  logic                       clk_i,
  input  logic                       rst_i,
  input  logic                       flush_i,
  input  logic                       fetch_valid_i,
  input  logic [XLEN-1:0]            fetch_pc_i,
  input  logic [31:0]                fetch_instr_i,
  output logic                       fetch_ready_o,
  output logic                       dec_valid_o,
  output logic [XLEN-1:0]            dec_pc_o,
  output logic [31:0]                dec_instr_o,
  input  logic                       dec_ready_i,
  output logic [$clog2(DEPTH):0]     count_o
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

  logic [XLEN-1:0] pc_q    [DEPTH];
  logic [XLEN-1:0] pc_d    [DEPTH];
  logic [31:0]     instr_q [DEPTH];
  logic [31:0]     instr_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            push, pop;

  always_comb begin
    // Readiness deliberately ignores a same-cycle pop to keep the path short.
    fetch_ready_o = (count_q != FULL_COUNT) && !flush_i;
    dec_valid_o   = (count_q != '0);
    push          = fetch_valid_i && fetch_ready_o;
    pop           = dec_valid_o && dec_ready_i && !flush_i;

    dec_pc_o      = dec_valid_o ? pc_q[rd_ptr_q]    : '0;
    dec_instr_o   = dec_valid_o ? instr_q[rd_ptr_q] : NOP;
    count_o       = count_q;
  end

  always_comb begin
    pc_d     = pc_q;
    instr_d  = instr_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (flush_i) begin
      // Storage is left intact; the count==0 output mux hides stale entries.
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
    end else begin
      if (push) begin
        pc_d[wr_ptr_q]    = fetch_pc_i;
        instr_d[wr_ptr_q] = fetch_instr_i;
        wr_ptr_d          = wr_ptr_q + PW'(1);
      end
      if (pop) begin
        rd_ptr_d = rd_ptr_q + PW'(1);
      end
      case ({push, pop})
        2'b10:   count_d = count_q + CW'(1);
        2'b01:   count_d = count_q - CW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      for (int i = 0; i < DEPTH; i++) begin
        pc_q[i]    <= '0;
        instr_q[i] <= NOP;
      end
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

endmodule

// File: tb/tb_if_id_queue.sv
// Directed bench for if_id_queue: reset, single pass, backpressure, wrap, flush, async reset.
module tb_if_id_queue;

  localparam logic [31:0] NOP = 32'h00000013;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        flush_i;
  logic        fetch_valid_i;
  logic [31:0] fetch_pc_i;
  logic [31:0] fetch_instr_i;
  logic        fetch_ready_o;
  logic        dec_valid_o;
  logic [31:0] dec_pc_o;
  logic [31:0] dec_instr_o;
  logic        dec_ready_i;
  logic [1:0]  count_o;

  int checks = 0;
  int errors = 0;

  if_id_queue #(.DEPTH(2), .XLEN(32), .NOP(NOP)) dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .flush_i       (flush_i),
    .fetch_valid_i (fetch_valid_i),
    .fetch_pc_i    (fetch_pc_i),
    .fetch_instr_i (fetch_instr_i),
    .fetch_ready_o (fetch_ready_o),
    .dec_valid_o   (dec_valid_o),
    .dec_pc_o      (dec_pc_o),
    .dec_instr_o   (dec_instr_o),
    .dec_ready_i   (dec_ready_i),
    .count_o       (count_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end else begin
      $display("ok   %s: %0h", tag, obs);
    end
  endtask

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic offer(input logic v, input logic [31:0] pc, input logic [31:0] ins);
    fetch_valid_i = v;
    fetch_pc_i    = pc;
    fetch_instr_i = ins;
  endtask

  task automatic expect_empty(input string tag);
    check({tag, ".valid"}, dec_valid_o, 1'b0);
    check({tag, ".instr"}, dec_instr_o, NOP);
    check({tag, ".pc"},    dec_pc_o,    32'h0);
    check({tag, ".count"}, count_o,     2'd0);
  endtask

  initial begin
    rst_i = 1'b0; flush_i = 1'b0; dec_ready_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);

    // 1: reset, then idle with dec_ready high on an empty queue
    #3;
    expect_empty("rst");
    check("rst.ready", fetch_ready_o, 1'b1);
    tick(); tick();
    rst_i = 1'b1;
    dec_ready_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      expect_empty($sformatf("idle%0d", i));
      check($sformatf("idle%0d.ready", i), fetch_ready_o, 1'b1);
    end

    // 2: single pass
    offer(1'b1, 32'h0, 32'h00500093);
    #1;
    check("p1.ready", fetch_ready_o, 1'b1);
    check("p1.nopass", dec_valid_o, 1'b0);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("p1.valid", dec_valid_o, 1'b1);
    check("p1.instr", dec_instr_o, 32'h00500093);
    check("p1.count", count_o, 2'd1);
    tick();
    expect_empty("p1.after");

    // 3: fill and backpressure
    dec_ready_i = 1'b0;
    offer(1'b1, 32'h04, 32'h00400113);
    tick();
    offer(1'b1, 32'h08, 32'h00800193);
    tick();
    offer(1'b1, 32'h0C, 32'h00C00213);
    #1;
    check("full.count", count_o, 2'd2);
    check("full.ready", fetch_ready_o, 1'b0);
    check("full.head", dec_pc_o, 32'h04);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    check("full.hold", count_o, 2'd2);
    dec_ready_i = 1'b1;
    #1;
    check("pop0.pc", dec_pc_o, 32'h04);
    check("pop0.instr", dec_instr_o, 32'h00400113);
    tick();
    check("pop1.pc", dec_pc_o, 32'h08);
    check("pop1.instr", dec_instr_o, 32'h00800193);
    check("pop1.count", count_o, 2'd1);
    tick();
    expect_empty("drain");

    // 4: streaming push+pop every cycle across pointer wrap
    dec_ready_i = 1'b1;
    for (int i = 0; i < 10; i++) begin
      offer(1'b1, 32'(4 * i), 32'h00000093 | (32'(i) << 20));
      #1;
      if (i > 0) begin
        check($sformatf("s%0d.pc", i), dec_pc_o, 32'(4 * (i - 1)));
        check($sformatf("s%0d.instr", i), dec_instr_o, 32'h00000093 | (32'(i - 1) << 20));
        check($sformatf("s%0d.count", i), count_o, 2'd1);
      end
      tick();
    end
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("s_last.pc", dec_pc_o, 32'h24);
    check("s_last.count", count_o, 2'd1);
    tick();
    expect_empty("s_end");

    // 5: flush with a full queue and a push on offer
    dec_ready_i = 1'b0;
    offer(1'b1, 32'h40, 32'h04000293);
    tick();
    offer(1'b1, 32'h44, 32'h04400313);
    tick();
    offer(1'b1, 32'h48, 32'h04800393);
    flush_i = 1'b1;
    dec_ready_i = 1'b1;
    #1;
    check("fl.count", count_o, 2'd2);
    check("fl.ready", fetch_ready_o, 1'b0);
    check("fl.valid", dec_valid_o, 1'b1);
    tick();
    flush_i = 1'b0;
    dec_ready_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #1;
    expect_empty("fl.after");
    check("fl.after.ready", fetch_ready_o, 1'b1);
    offer(1'b1, 32'h100, 32'h10000413);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("fl.new.pc", dec_pc_o, 32'h100);
    check("fl.new.instr", dec_instr_o, 32'h10000413);
    check("fl.new.count", count_o, 2'd1);
    // flush with room available must still refuse the offered push
    flush_i = 1'b1;
    offer(1'b1, 32'h104, 32'h10400493);
    #1;
    check("fl2.ready", fetch_ready_o, 1'b0);
    tick();
    flush_i = 1'b0;
    offer(1'b0, 32'h0, 32'h0);
    #1;
    expect_empty("fl2.after");

    // 6: asynchronous reset between edges
    offer(1'b1, 32'h200, 32'h20000513);
    tick();
    offer(1'b0, 32'h0, 32'h0);
    #1;
    check("ar.count", count_o, 2'd1);
    check("ar.valid", dec_valid_o, 1'b1);
    #1;
    rst_i = 1'b0;
    #1;
    expect_empty("ar.async");
    check("ar.ready", fetch_ready_o, 1'b1);
    rst_i = 1'b1;
    tick();
    expect_empty("ar.release");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
